// File: rtl/nibble_serial_alu_ctrl_pkg.sv
// Shared encodings for the nibble-serial add/subtract sequencer.
package nibble_serial_alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/nibble_serial_alu_ctrl_if.sv
// Operand/request and result/flag bundle between the keypad side and the sequencer.
interface nibble_serial_alu_ctrl_if #(parameter int WIDTH = 16);

    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, op_sub, a, b,
        input  busy, done, result, cout, ovf, zero
    );

    modport slave (
        input  start, op_sub, a, b,
        output busy, done, result, cout, ovf, zero
    );

endinterface

// File: rtl/nibble_serial_alu_ctrl_cla4.sv
// Combinational 4-bit carry-lookahead slice; c3 is the carry into bit 3 for overflow detection.
module nibble_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       c3,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;
    logic       grp_g;
    logic       grp_p;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    // Second lookahead level: group generate/propagate give the nibble carry-out directly.
    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign grp_p = &p;

    assign cout = grp_g | (grp_p & cin);
    assign c3   = c[3];
    assign s    = p ^ c;

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract: one nibble per clock through a shared CLA slice.
module nibble_serial_alu_ctrl
    import nibble_serial_alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    nibble_serial_alu_ctrl_if.slave  bus
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] next_result;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic             busy_r;
    logic             done_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       sum_nib;
    logic             c3;
    logic             cnib;
    logic             last;

    // next_result lets the zero flag see the final nibble in the same edge it is written.
    always_comb begin
        nib_a       = opa[4*idx +: 4];
        nib_b       = opb[4*idx +: 4];
        next_result = result_r;
        next_result[4*idx +: 4] = sum_nib;
    end

    assign last = (idx == IDX_W'(NIB - 1));

    nibble_cla4 u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry),
        .s    (sum_nib),
        .c3   (c3),
        .cout (cnib)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            opa      <= '0;
            opb      <= '0;
            result_r <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
            zero_r   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        // Subtract is A + ~B + 1: the +1 rides in on the initial carry.
                        opa    <= bus.a;
                        opb    <= (bus.op_sub == OP_SUB) ? ~bus.b : bus.b;
                        carry  <= (bus.op_sub == OP_SUB);
                        idx    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    result_r <= next_result;
                    carry    <= cnib;
                    idx      <= idx + IDX_W'(1);
                    if (last) begin
                        cout_r <= cnib;
                        ovf_r  <= c3 ^ cnib;
                        zero_r <= (next_result == '0);
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.cout   = cout_r;
    assign bus.ovf    = ovf_r;
    assign bus.zero   = zero_r;

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Self-checking bench for nibble_serial_alu_ctrl (WIDTH=16): directed cases plus randomized ops vs an arithmetic model.
module tb_nibble_serial_alu_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   last_done_cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    nibble_serial_alu_ctrl_if #(.WIDTH(16)) bus ();

    nibble_serial_alu_ctrl #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        c;
        logic        o;
        logic        z;
    } vec_t;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, flags from range checks.
    task automatic model(input logic op, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] r, output logic c, output logic o, output logic z);
        int ux, uy, sx, sy, full, sfull;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (op) begin
            full  = ux - uy;
            sfull = sx - sy;
            c     = (ux >= uy);
        end else begin
            full  = ux + uy;
            sfull = sx + sy;
            c     = (full > 65535);
        end
        r = full[15:0];
        o = (sfull > 32767) || (sfull < -32768);
        z = (r == 16'h0000);
    endtask

    task automatic applyStimulus(input logic op, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op_sub = op;
        bus.a      = x;
        bus.b      = y;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        bus.start  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] er,
                               input logic ec, input logic eo, input logic ez);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        last_done_cyc = cyc;
        checkValue({tag, "_done"},    32'(bus.done), 32'd1);
        checkValue({tag, "_latency"}, 32'(cyc - accept_cyc), 32'd4);
        checkValue({tag, "_busy"},    32'(bus.busy), 32'd0);
        checkValue({tag, "_result"},  32'(bus.result), 32'(er));
        checkValue({tag, "_cout"},    32'(bus.cout), 32'(ec));
        checkValue({tag, "_ovf"},     32'(bus.ovf), 32'(eo));
        checkValue({tag, "_zero"},    32'(bus.zero), 32'(ez));
    endtask

    task automatic checkIdleZero(input string tag);
        checkValue({tag, "_busy"},   32'(bus.busy), 32'd0);
        checkValue({tag, "_done"},   32'(bus.done), 32'd0);
        checkValue({tag, "_result"}, 32'(bus.result), 32'd0);
        checkValue({tag, "_cout"},   32'(bus.cout), 32'd0);
        checkValue({tag, "_ovf"},    32'(bus.ovf), 32'd0);
        checkValue({tag, "_zero"},   32'(bus.zero), 32'd0);
    endtask

    vec_t dir [6] = '{
        '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0},
        '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1},
        '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0},
        '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0},
        '{1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0},
        '{1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1}
    };

    initial begin
        logic [15:0] er, x, y;
        logic        ec, eo, ez, op;
        int          d1, seen;

        bus.start  = 1'b0;
        bus.op_sub = 1'b0;
        bus.a      = '0;
        bus.b      = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkIdleZero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        for (int i = 0; i < 6; i++) begin
            applyStimulus(dir[i].op, dir[i].a, dir[i].b);
            checkValue($sformatf("dir%0d_busy_run", i), 32'(bus.busy), 32'd1);
            checkOutput($sformatf("dir%0d", i), dir[i].r, dir[i].c, dir[i].o, dir[i].z);
            @(posedge clk);
            #1;
            checkValue($sformatf("dir%0d_done_pulse", i), 32'(bus.done), 32'd0);
        end

        // Start during RUN is ignored
        applyStimulus(1'b0, 16'h1111, 16'h2222);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h0F0F;
        bus.b     = 16'h0F0F;
        bus.op_sub = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("ignore_start", 16'h3333, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkValue("ignore_start_idle", 32'(bus.busy), 32'd0);

        // Back-to-back: start held through DONE
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op_sub = 1'b0;
        bus.a      = 16'h00F0;
        bus.b      = 16'h0010;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        bus.op_sub = 1'b1;
        bus.a      = 16'h1000;
        bus.b      = 16'h0001;
        checkOutput("b2b_first", 16'h0100, 1'b0, 1'b0, 1'b0);
        d1 = last_done_cyc;
        accept_cyc = cyc + 1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkValue("b2b_no_idle", 32'(bus.busy), 32'd1);
        checkOutput("b2b_second", 16'h0FFF, 1'b1, 1'b0, 1'b0);
        checkValue("b2b_spacing", 32'(last_done_cyc - d1), 32'd5);

        // Asynchronous reset in the 2nd RUN cycle
        applyStimulus(1'b0, 16'hAAAA, 16'h5555);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkIdleZero("abort");
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) seen++;
        end
        checkValue("abort_no_done", 32'(seen), 32'd0);
        applyStimulus(1'b0, 16'h0001, 16'h0001);
        checkOutput("after_abort", 16'h0002, 1'b0, 1'b0, 1'b0);

        // Randomized ops with boundary-biased operands
        for (int i = 0; i < 40; i++) begin
            op = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: x = 16'h0000;
                1: x = 16'hFFFF;
                2: x = 16'h7FFF;
                3: x = 16'h8000;
                default: x = 16'($urandom);
            endcase
            y = (i % 3 == 0) ? x : 16'($urandom);
            model(op, x, y, er, ec, eo, ez);
            applyStimulus(op, x, y);
            checkOutput($sformatf("rand%0d", i), er, ec, eo, ez);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nibble_serial_alu_ctrl.md
Name: nibble_serial_alu_ctrl

Overview:
- Sequencer that computes WIDTH-bit add/subtract over multiple cycles, one 4-bit nibble per clock.
- Time-shares a single 4-bit propagate/generate slice plus lookahead-carry logic.
- Sits between the calculator keypad/operand registers and the display formatter.
- Replaces a full-width adder with an area-cheap serial datapath, and also produces carry, overflow and zero flags.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4, minimum 4.
- NIB, WIDTH/4, derived: number of nibble steps per operation; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an operation; accepted only when busy=0.
- op_sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while nibbles are being processed.
- done  output  1  single-cycle pulse: result and flags are valid.
- result  output  WIDTH  sum/difference; held until the next accepted start.
- cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement overflow.
- zero  output  1  result == 0.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0, zero=0; nibble index=0, carry register=0.
- States: IDLE, RUN, DONE.
- Accept: at a rising edge with start=1 and state in {IDLE, DONE}:
  - latch A into operand register opA;
  - latch B into opB, inverted if op_sub=1;
  - carry register <= op_sub;
  - index <= 0; state <= RUN.
- start=1 while in RUN is ignored; operands are not re-sampled.
- RUN, per cycle, for nibble i = index:
  - p = opA[i] xor opB[i], g = opA[i] and opB[i];
  - lookahead: c1 = g0|p0c0, c2 = g1|p1g0|p1p0c0, etc.; cnib = carry out of bit 3;
  - sum nibble = p xor {c3,c2,c1,c0};
  - at the edge: result nibble i <= sum nibble; carry register <= cnib; index++.
- On the last nibble (index = NIB-1):
  - cout <= cnib;
  - ovf <= c3 xor cnib of that nibble;
  - zero <= (assembled result == 0), computed including the final nibble;
  - state <= DONE.
- DONE lasts exactly one cycle, then returns to IDLE unless start is accepted in that cycle, in which case it goes directly to RUN.
- Outputs:
  - busy = (state == RUN);
  - done = (state == DONE);
  - result and flags are registered and stable from DONE until the next accept.
- result/cout/ovf/zero are not cleared at accept; they update nibble-by-nibble and flag-at-end. Consumers use them only at or after done.
- Latency: start sampled at edge E; RUN occupies edges E+1..E+NIB; done is high in the cycle following edge E+NIB. With WIDTH=16, done is high 4 cycles after the accept edge. Back-to-back throughput is one operation per NIB+1 cycles.
- Wrap-around: the result is modulo 2^WIDTH; the carry beyond the MSB appears only on cout.
- Reset mid-operation: everything returns to reset values immediately; no done is ever produced for an aborted operation.
- WIDTH=4: a single RUN cycle, then DONE.

Decomposition:
- Shared calc package holds:
  - the state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the op encoding: OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module: nibble_cla4, purely combinational.
  - Inputs: a[3:0], b[3:0], cin. Outputs: s[3:0], c3, cout.
  - Built from per-bit p/g generation plus two-level lookahead.
- The controller holds the FSM, operand registers, index counter and carry register.

Test Plan (WIDTH=16):
- Add 0x1234 + 0x4321 -> after 4 busy cycles done pulses 1 cycle; result=0x5555, cout=0, ovf=0, zero=0.
- Add 0xFFFF + 0x0001 -> result=0x0000, cout=1, ovf=0, zero=1; checks carry ripple across all 4 nibble steps.
- Add 0x7FFF + 0x0001 -> result=0x8000, ovf=1, cout=0. Sub 0x8000 - 0x0001 -> result=0x7FFF, ovf=1, cout=1.
- Sub 0x0003 - 0x0005 -> result=0xFFFE, cout=0 (borrow), ovf=0. Sub 0x0005 - 0x0005 -> result=0x0000, zero=1, cout=1.
- Start re-asserted with new operands during RUN -> ignored; original result is delivered. Start held high in DONE -> the next op begins with no IDLE cycle and done spacing is 5 cycles.
- rst pulsed at the 2nd RUN cycle -> busy, done, result and flags go to 0 asynchronously and no done follows. A subsequent 0x0001 + 0x0001 yields 0x0002.
